// File: rtl/exc_arbiter_pkg.sv
// Shared definitions for the exception arbiter: code widths, exception codes,
// Status bit positions, FSM states and the EPC helper.
package exc_arbiter_pkg;

    localparam int EXC_CODE_WIDTH = 5;
    localparam int INT_MASK_WIDTH = 8;

    // Exception codes as seen by cp0; EC_ERET and EC_NONE sit in unused encodings.
    localparam logic [EXC_CODE_WIDTH-1:0] EC_INT     = 5'h00;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_ADEL    = 5'h04;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_ADES    = 5'h05;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_SYSCALL = 5'h08;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_BP      = 5'h09;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_RI      = 5'h0a;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_OV      = 5'h0c;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_ERET    = 5'h1e;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_NONE    = 5'h1f;

    // Status register bit positions
    localparam int STATUS_IE    = 0;
    localparam int STATUS_EXL   = 1;
    localparam int STATUS_IM_LO = 8;
    localparam int STATUS_IM_HI = 15;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_JMP = 2'd2
    } arb_state_t;

    // An instruction in a delay slot restarts at its branch, one word earlier.
    function automatic logic [31:0] calc_epc(input logic [31:0] pc, input logic in_bds);
        return in_bds ? (pc - 32'd4) : pc;
    endfunction

endpackage

// File: rtl/exc_arbiter_irq_sync.sv
// Multi-flop synchronizer for asynchronous level-sensitive interrupt lines.
module irq_sync #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] chain [STAGES];

    // Shift each line through the flop chain; reset clears every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) chain[i] <= '0;
        end else begin
            chain[0] <= async_in;
            for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
        end
    end

    assign sync_out = chain[STAGES-1];

endmodule

// File: rtl/exc_arbiter.sv
// Exception/interrupt arbiter feeding cp0: selects one event at the commit
// stage, issues a one-cycle pulse with flush, stalls until cp0 redirects.
module exc_arbiter
    import exc_arbiter_pkg::*;
#(
    parameter int NR_HW_IRQ   = 5,
    parameter int SYNC_STAGES = 2,
    parameter int JMP_TIMEOUT = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NR_HW_IRQ-1:0]      hw_irq,
    input  logic                      int_timer_req,
    input  logic [31:0]               cp0_status,
    output logic [INT_MASK_WIDTH-1:0] cause_ip,
    input  logic                      mem_valid,
    input  logic [EXC_CODE_WIDTH-1:0] mem_exc_code,
    input  logic [31:0]               mem_pc,
    input  logic                      mem_in_bds,
    input  logic [31:0]               mem_badvaddr,
    output logic [EXC_CODE_WIDTH-1:0] exc_code,
    output logic [31:0]               exc_epc,
    output logic [31:0]               exc_badvaddr,
    input  logic                      exc_jmp_flag,
    output logic                      pipe_flush,
    output logic                      pipe_stall,
    output logic                      timeout_err
);

    localparam logic [3:0] TMO_LIM = 4'(JMP_TIMEOUT);

    arb_state_t                state, state_nxt;
    logic [3:0]                cnt, cnt_nxt;
    logic                      tmo_set, load;
    logic [NR_HW_IRQ-1:0]      hw_sync;
    logic                      int_pend, exc_req, eret_req, trigger;
    logic [EXC_CODE_WIDTH-1:0] ev_code, code_q;
    logic [31:0]               ev_epc, ev_bad, epc_q, bad_q;
    logic                      unused_status;

    assign unused_status = ^{cp0_status[31:16], cp0_status[7:2]};

    irq_sync #(
        .WIDTH  (NR_HW_IRQ),
        .STAGES (SYNC_STAGES)
    ) u_irq_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (hw_irq),
        .sync_out (hw_sync)
    );

    // Pending-interrupt vector for cp0: timer on top, synchronized lines at [2+].
    always_comb begin
        cause_ip = '0;
        cause_ip[INT_MASK_WIDTH-1] = int_timer_req;
        cause_ip[2 +: NR_HW_IRQ] = hw_sync;
    end

    // Pick the event for the instruction at commit; interrupts outrank exceptions.
    always_comb begin
        int_pend = cp0_status[STATUS_IE] & ~cp0_status[STATUS_EXL]
                 & (|(cause_ip & cp0_status[STATUS_IM_HI:STATUS_IM_LO]));
        exc_req  = (mem_exc_code != EC_NONE) && (mem_exc_code != EC_ERET);
        eret_req = (mem_exc_code == EC_ERET);
        trigger  = 1'b0;
        ev_code  = EC_NONE;
        ev_epc   = '0;
        ev_bad   = '0;
        if (mem_valid) begin
            if (int_pend) begin
                trigger = 1'b1;
                ev_code = EC_INT;
                ev_epc  = calc_epc(mem_pc, mem_in_bds);
            end else if (exc_req) begin
                trigger = 1'b1;
                ev_code = mem_exc_code;
                ev_epc  = calc_epc(mem_pc, mem_in_bds);
                ev_bad  = mem_badvaddr;
            end else if (eret_req) begin
                trigger = 1'b1;
                ev_code = EC_ERET;
            end
        end
    end

    // Next-state, wait counter and pipeline control outputs.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        tmo_set    = 1'b0;
        load       = 1'b0;
        exc_code   = EC_NONE;
        pipe_flush = 1'b0;
        pipe_stall = 1'b0;
        case (state)
            ST_IDLE: begin
                if (trigger) begin
                    state_nxt = ST_ISSUE;
                    load      = 1'b1;
                end
            end
            ST_ISSUE: begin
                exc_code   = code_q;
                pipe_flush = 1'b1;
                pipe_stall = 1'b1;
                state_nxt  = ST_WAIT_JMP;
                cnt_nxt    = '0;
            end
            ST_WAIT_JMP: begin
                pipe_stall = 1'b1;
                if (exc_jmp_flag) begin
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                    if (cnt_nxt == TMO_LIM) begin
                        tmo_set   = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, counter, sticky timeout flag and the captured event payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            timeout_err <= 1'b0;
            code_q      <= EC_NONE;
            epc_q       <= '0;
            bad_q       <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (tmo_set) timeout_err <= 1'b1;
            if (load) begin
                code_q <= ev_code;
                epc_q  <= ev_epc;
                bad_q  <= ev_bad;
            end
        end
    end

    assign exc_epc      = epc_q;
    assign exc_badvaddr = bad_q;

endmodule

// File: tb/tb_exc_arbiter.sv
// Self-checking bench for exc_arbiter: per-cycle reference model plus
// directed scenarios with literal expectations, then randomized traffic.
module tb_exc_arbiter;
    import exc_arbiter_pkg::*;

    localparam int NR = 5;
    localparam int SS = 2;
    localparam int JT = 7;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  hw_irq;
    logic        int_timer_req;
    logic [31:0] cp0_status;
    logic [7:0]  cause_ip;
    logic        mem_valid;
    logic [4:0]  mem_exc_code;
    logic [31:0] mem_pc;
    logic        mem_in_bds;
    logic [31:0] mem_badvaddr;
    logic [4:0]  exc_code;
    logic [31:0] exc_epc;
    logic [31:0] exc_badvaddr;
    logic        exc_jmp_flag;
    logic        pipe_flush;
    logic        pipe_stall;
    logic        timeout_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    exc_arbiter #(.NR_HW_IRQ(NR), .SYNC_STAGES(SS), .JMP_TIMEOUT(JT)) dut (
        .clk           (clk),
        .rst           (rst),
        .hw_irq        (hw_irq),
        .int_timer_req (int_timer_req),
        .cp0_status    (cp0_status),
        .cause_ip      (cause_ip),
        .mem_valid     (mem_valid),
        .mem_exc_code  (mem_exc_code),
        .mem_pc        (mem_pc),
        .mem_in_bds    (mem_in_bds),
        .mem_badvaddr  (mem_badvaddr),
        .exc_code      (exc_code),
        .exc_epc       (exc_epc),
        .exc_badvaddr  (exc_badvaddr),
        .exc_jmp_flag  (exc_jmp_flag),
        .pipe_flush    (pipe_flush),
        .pipe_stall    (pipe_stall),
        .timeout_err   (timeout_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model. m_hist holds the last SS hw_irq samples (oldest last);
    // m_age is -1 when free, 0 on the pulse cycle, k>=1 on the k-th waiting cycle.
    logic [4:0]  m_hist [SS];
    int          m_age = -1;
    logic [4:0]  m_code = EC_NONE;
    logic [31:0] m_epc = '0;
    logic [31:0] m_bad = '0;
    logic        m_tmo = 1'b0;
    bit          m_live = 1'b0;
    logic [7:0]  m_cip;
    logic        m_pend;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SS; i++) m_hist[i] = '0;
            m_age  = -1;
            m_code = EC_NONE;
            m_epc  = '0;
            m_bad  = '0;
            m_tmo  = 1'b0;
            m_live = 1'b1;
        end else if (m_live) begin
            m_cip  = {int_timer_req, m_hist[SS-1], 2'b00};
            m_pend = cp0_status[0] && !cp0_status[1] && ((m_cip & cp0_status[15:8]) != 8'd0);
            if (m_age < 0) begin
                if (mem_valid && m_pend) begin
                    m_age  = 0;
                    m_code = EC_INT;
                    m_epc  = mem_in_bds ? mem_pc - 32'd4 : mem_pc;
                    m_bad  = 32'd0;
                end else if (mem_valid && mem_exc_code != EC_NONE && mem_exc_code != EC_ERET) begin
                    m_age  = 0;
                    m_code = mem_exc_code;
                    m_epc  = mem_in_bds ? mem_pc - 32'd4 : mem_pc;
                    m_bad  = mem_badvaddr;
                end else if (mem_valid && mem_exc_code == EC_ERET) begin
                    m_age  = 0;
                    m_code = EC_ERET;
                    m_epc  = 32'd0;
                    m_bad  = 32'd0;
                end
            end else if (m_age == 0) begin
                m_age = 1;
            end else if (exc_jmp_flag) begin
                m_age = -1;
            end else if (m_age == JT) begin
                m_age = -1;
                m_tmo = 1'b1;
            end else begin
                m_age++;
            end
            for (int i = SS-1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = hw_irq;
        end
    end

    // Compare every DUT output against the model each cycle once reset has been seen.
    always @(negedge clk) begin
        if (m_live) begin
            chk("exc_code", 32'(exc_code), 32'((m_age == 0) ? m_code : EC_NONE));
            chk("exc_epc", exc_epc, m_epc);
            chk("exc_badvaddr", exc_badvaddr, m_bad);
            chk("pipe_flush", 32'(pipe_flush), 32'(m_age == 0));
            chk("pipe_stall", 32'(pipe_stall), 32'(m_age >= 0));
            chk("timeout_err", 32'(timeout_err), 32'(m_tmo));
            chk("cause_ip", 32'(cause_ip), 32'({int_timer_req, m_hist[SS-1], 2'b00}));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_pulse(input int max, output logic [4:0] c, output logic [31:0] e,
                              output logic [31:0] b, output logic f);
        bit got = 1'b0;
        c = EC_NONE; e = '0; b = '0; f = 1'b0;
        for (int i = 0; i < max && !got; i++) begin
            @(negedge clk);
            if (exc_code !== EC_NONE) begin
                got = 1'b1;
                c = exc_code; e = exc_epc; b = exc_badvaddr; f = pipe_flush;
            end
        end
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL pulse_wait actual=no_pulse required=pulse_within_%0d_cycles", max);
        end
    endtask

    // Step into the wait state, retire the request and answer with one jump flag.
    task automatic release_jmp();
        tick();
        mem_valid     = 1'b0;
        mem_exc_code  = EC_NONE;
        hw_irq        = '0;
        int_timer_req = 1'b0;
        exc_jmp_flag  = 1'b1;
        tick();
        exc_jmp_flag  = 1'b0;
    endtask

    logic [4:0]  pc_code;
    logic [31:0] pc_epc, pc_bad;
    logic        pc_flush;
    int          stall_n;
    logic [4:0]  codes [8];

    initial begin
        codes = '{EC_NONE, EC_NONE, EC_NONE, EC_ADEL, EC_SYSCALL, EC_BP, EC_OV, EC_ERET};
        rst = 1'b1; hw_irq = '0; int_timer_req = 1'b0; cp0_status = '0;
        mem_valid = 1'b0; mem_exc_code = EC_NONE; mem_pc = '0; mem_in_bds = 1'b0;
        mem_badvaddr = '0; exc_jmp_flag = 1'b0;
        tick(); tick(); tick();
        chk("rst_code", 32'(exc_code), 32'(EC_NONE));
        chk("rst_epc", exc_epc, 32'd0);
        chk("rst_stall", 32'(pipe_stall), 32'd0);
        chk("rst_tmo", 32'(timeout_err), 32'd0);
        chk("rst_cause", 32'(cause_ip), 32'd0);
        rst = 1'b0;

        // hw_irq[3] lands on cause_ip[5]; IM[5] and IM[2] enabled, IE=1
        cp0_status = 32'h0000_2401; hw_irq = 5'b01000; mem_valid = 1'b1;
        mem_pc = 32'h8000_0100; mem_in_bds = 1'b0; mem_exc_code = EC_NONE;
        tick();
        chk("t1_ip5_after1", 32'(cause_ip[5]), 32'd0);
        tick();
        chk("t1_ip5_after2", 32'(cause_ip[5]), 32'd1);
        wait_pulse(5, pc_code, pc_epc, pc_bad, pc_flush);
        chk("t1_code", 32'(pc_code), 32'(EC_INT));
        chk("t1_epc", pc_epc, 32'h8000_0100);
        chk("t1_bad", pc_bad, 32'd0);
        chk("t1_flush", 32'(pc_flush), 32'd1);
        chk("t1_model_epc", m_epc, 32'h8000_0100);
        release_jmp();
        chk("t1_stall_dropped", 32'(pipe_stall), 32'd0);
        tick(); tick(); tick();

        // Address error in a delay slot
        cp0_status = 32'd0; mem_valid = 1'b1; mem_exc_code = EC_ADEL;
        mem_badvaddr = 32'h0000_0003; mem_in_bds = 1'b1; mem_pc = 32'h8000_0208;
        wait_pulse(5, pc_code, pc_epc, pc_bad, pc_flush);
        chk("t2_code", 32'(pc_code), 32'(EC_ADEL));
        chk("t2_epc", pc_epc, 32'h8000_0204);
        chk("t2_bad", pc_bad, 32'h0000_0003);
        chk("t2_model_bad", m_bad, 32'h0000_0003);
        release_jmp();

        // Delay-slot EPC wraps below address zero
        mem_valid = 1'b1; mem_exc_code = EC_OV; mem_in_bds = 1'b1; mem_pc = 32'd0;
        wait_pulse(5, pc_code, pc_epc, pc_bad, pc_flush);
        chk("t2b_epc_wrap", pc_epc, 32'hFFFF_FFFC);
        release_jmp();

        // Interrupt and syscall together: interrupt wins
        cp0_status = 32'h0000_8001; int_timer_req = 1'b1; mem_valid = 1'b1;
        mem_exc_code = EC_SYSCALL; mem_in_bds = 1'b0; mem_pc = 32'h8000_0300;
        mem_badvaddr = 32'h1234_5678;
        wait_pulse(5, pc_code, pc_epc, pc_bad, pc_flush);
        chk("t3_code", 32'(pc_code), 32'(EC_INT));
        chk("t3_epc", pc_epc, 32'h8000_0300);
        chk("t3_bad", pc_bad, 32'd0);
        release_jmp();

        // EXL blocks the timer interrupt; ERET still goes through
        cp0_status = 32'h0000_FF03; int_timer_req = 1'b1; mem_valid = 1'b1;
        mem_exc_code = EC_NONE; mem_pc = 32'h8000_0400;
        tick(); tick(); tick(); tick();
        chk("t4_no_pulse", 32'(exc_code), 32'(EC_NONE));
        chk("t4_no_stall", 32'(pipe_stall), 32'd0);
        mem_exc_code = EC_ERET;
        wait_pulse(5, pc_code, pc_epc, pc_bad, pc_flush);
        chk("t4_code", 32'(pc_code), 32'(EC_ERET));
        chk("t4_epc", pc_epc, 32'd0);
        release_jmp();
        cp0_status = 32'd0;

        // cp0 never answers: 1 issue + 7 wait cycles of stall, then sticky timeout
        mem_valid = 1'b1; mem_exc_code = EC_BP; mem_pc = 32'h8000_0500; mem_in_bds = 1'b0;
        wait_pulse(5, pc_code, pc_epc, pc_bad, pc_flush);
        tick();
        mem_valid = 1'b0; mem_exc_code = EC_NONE;
        stall_n = 1 + (pipe_stall ? 1 : 0);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (pipe_stall) stall_n++;
            else break;
        end
        chk("t5_stall_cycles", 32'(stall_n), 32'd8);
        chk("t5_tmo_set", 32'(timeout_err), 32'd1);
        tick(); tick(); tick();
        chk("t5_tmo_sticky", 32'(timeout_err), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_tmo_cleared", 32'(timeout_err), 32'd0);

        // Reset in the wait state aborts; a held trigger then issues once
        hw_irq = 5'b11111; mem_valid = 1'b1; mem_exc_code = EC_RI; mem_pc = 32'h8000_0600;
        wait_pulse(5, pc_code, pc_epc, pc_bad, pc_flush);
        tick();
        rst = 1'b1;
        tick();
        chk("t6_stall_rst", 32'(pipe_stall), 32'd0);
        chk("t6_code_rst", 32'(exc_code), 32'(EC_NONE));
        chk("t6_cause_rst", 32'(cause_ip), 32'd0);
        rst = 1'b0;
        wait_pulse(6, pc_code, pc_epc, pc_bad, pc_flush);
        chk("t6_code", 32'(pc_code), 32'(EC_RI));
        chk("t6_epc", pc_epc, 32'h8000_0600);
        release_jmp();
        tick(); tick();

        // Randomized traffic, checked by the per-cycle model
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 7) == 0) hw_irq = 5'($urandom);
            if ($urandom_range(0, 9) == 0) int_timer_req = ~int_timer_req;
            if ($urandom_range(0, 19) == 0) begin
                cp0_status = $urandom;
                cp0_status[0] = ($urandom_range(0, 3) != 0);
                cp0_status[1] = ($urandom_range(0, 3) == 0);
            end
            mem_valid    = 1'($urandom);
            mem_exc_code = codes[$urandom_range(0, 7)];
            mem_pc       = ($urandom_range(0, 15) == 0) ? 32'd0 : ($urandom & 32'hFFFF_FFFC);
            mem_in_bds   = 1'($urandom);
            mem_badvaddr = $urandom;
            exc_jmp_flag = ($urandom_range(0, 3) == 0);
            tick();
        end
        rst = 1'b0; mem_valid = 1'b0; exc_jmp_flag = 1'b0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
